mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one load/store port of the system memory between the two CPU cores.
//  Sits in the sys_clk domain, after the per-core synchronizers and before the memory's load/store ports.
//  Grants requesters round-robin, holds one transaction in flight, and returns a one-cycle ack with read data.
//  A watchdog aborts any transaction the memory never completes.
// PARAMETERS
//  ADDR_W   11  memory word address width
//  DATA_W   32  data word width
//  TIMEOUT  15  max WAIT cycles before abort (>=1; counter width $clog2(TIMEOUT+1))
// PORTS
//  clk          in   1         sys_clk; all logic is on the rising edge
//  reset        in   1         asynchronous, active-high; clears all state
//  req_rd       in   2         per-core read request [0]=core0 [1]=core1; level, held until ack
//  req_wr       in   2         per-core write request; level, held until ack
//  req_radrs    in   2*ADDR_W  read addresses; core0 in [ADDR_W-1:0]
//  req_wadrs    in   2*ADDR_W  write addresses, same packing
//  req_wdata    in   2*DATA_W  write data, same packing
//  ack          out  2         one-cycle completion pulse per core
//  ack_err      out  1         high with ack when the transaction timed out
//  ack_rdata    out  DATA_W    read data, valid while ack is high for a read
//  busy         out  1         high when state != IDLE
//  mem_r_en     out  1         memory read enable
//  mem_radrs    out  ADDR_W    memory read address
//  mem_w_en     out  1         memory write enable
//  mem_wadrs    out  ADDR_W    memory write address
//  mem_wdata    out  DATA_W    memory write data
//  mem_r_valid  in   1         memory read complete
//  mem_w_valid  in   1         memory write complete
//  mem_rdata    in   DATA_W    memory read data, valid with mem_r_valid
// BEHAVIOUR
//  - Reset: state=IDLE; last_grant=1 so core0 wins the first tie.
//  - Reset values: ack, ack_err, ack_rdata, busy, mem_* enables, addresses and data are all 0; timer=0.
//  - All outputs are registered.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  - IDLE: candidates are the cores with req_rd|req_wr high.
//    - If none, stay in IDLE.
//    - If one, grant it.
//    - If both, grant the core != last_grant.
//    - Latch gnt, op, address and wdata, then go to ISSUE.
//  - Op select: write if req_wr is high, else read. With rd+wr both high, the write goes first and the read waits for a later grant.
//  - ISSUE: exactly one cycle.
//    - Drive mem_r_en or mem_w_en =1 with the latched address and data; the other enable stays 0.
//    - Clear timer, go to WAIT.
//  - WAIT: enables are 0 and addresses and data hold.
//    - Read op: completes on mem_r_valid and captures mem_rdata.
//    - Write op: completes on mem_w_valid.
//    - A valid of the wrong type is ignored.
//    - Otherwise timer++. When timer==TIMEOUT, abort: set err=1 and go to RESP.
//  - RESP: one cycle.
//    - ack[gnt]=1 and ack_err=err.
//    - ack_rdata = captured data for a read; 0 for a write or on error.
//    - last_grant=gnt. Go to IDLE.
//  - Requester protocol: hold req and address/data stable until ack, then deassert on the cycle after ack. The arbiter treats req still high in the IDLE that follows RESP as a new request.
//  - Minimum latency with memory valid 1 cycle after enable:
//    - req high in IDLE cycle 0, ISSUE cycle 1, valid in cycle 2, ack in cycle 3.
//    - Back-to-back grants are 4 cycles apart.
//  - Request drop mid-transaction (req falls after grant): the transaction still completes and ack is still pulsed.
//  - Reset mid-transaction: immediate abort and no ack; the enables drop asynchronously.
//  - Never more than one transaction outstanding; mem_r_en and mem_w_en are never both 1.
// TESTING
//  1. Reset: both reqs low -> busy=0, all mem_* and ack 0 for 10 cycles.
//  2. Core0 read 0x012, memory returns 0xDEADBEEF 1 cycle later -> mem_r_en pulse cycle 1 with radrs=0x012, ack=2'b01 cycle 3, ack_rdata=0xDEADBEEF, ack_err=0.
//  3. Both cores request a write continuously (core0 0x100<-0x11, core1 0x200<-0x22) -> grants alternate 0,1,0,1; mem_wadrs seq 0x100,0x200,0x100,0x200.
//  4. Core1 asserts rd+wr together -> write issued first; read issued on the next grant to core1 after core0 is served if core0 is pending.
//  5. Memory never returns valid, TIMEOUT=15 -> ack with ack_err=1 exactly 15 WAIT cycles after ISSUE, ack_rdata=0; next request is serviced normally.
//  6. Reset asserted during WAIT -> outputs 0 immediately, no ack; after release core0 wins a simultaneous tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets two cores share one memory load/store port.
// One transaction is in flight at a time, and a watchdog aborts any transaction the memory never completes.
module mem_port_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_rd,
  input  logic [1:0]            req_wr,
  input  logic [2*ADDR_W-1:0]   req_radrs,
  input  logic [2*ADDR_W-1:0]   req_wadrs,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            ack,
  output logic                  ack_err,
  output logic [DATA_W-1:0]     ack_rdata,
  output logic                  busy,
  output logic                  mem_r_en,
  output logic [ADDR_W-1:0]     mem_radrs,
  output logic                  mem_w_en,
  output logic [ADDR_W-1:0]     mem_wadrs,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_r_valid,
  input  logic                  mem_w_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                op_wr_q, op_wr_d;
  logic                last_grant_q, last_grant_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [1:0]          ack_q, ack_d;
  logic                ack_err_q, ack_err_d;
  logic [DATA_W-1:0]   ack_rdata_q, ack_rdata_d;
  logic                busy_q, busy_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic                mem_w_en_q, mem_w_en_d;
  logic [ADDR_W-1:0]   mem_radrs_q, mem_radrs_d;
  logic [ADDR_W-1:0]   mem_wadrs_q, mem_wadrs_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0]          cand_s;
  logic                pick_s;
  logic [TW-1:0]       timer_inc_s;

  assign cand_s      = req_rd | req_wr;
  // On a tie the core that was not served last wins; otherwise the lone requester wins.
  assign pick_s      = (cand_s == 2'b11) ? ~last_grant_q : cand_s[1];
  assign timer_inc_s = timer_q + TW'(1);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    op_wr_d      = op_wr_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    ack_d        = 2'b00;
    ack_err_d    = 1'b0;
    ack_rdata_d  = '0;
    mem_r_en_d   = 1'b0;
    mem_w_en_d   = 1'b0;
    mem_radrs_d  = mem_radrs_q;
    mem_wadrs_d  = mem_wadrs_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cand_s != 2'b00) begin
          gnt_d   = pick_s;
          op_wr_d = pick_s ? req_wr[1] : req_wr[0];
          if (pick_s ? req_wr[1] : req_wr[0]) begin
            mem_w_en_d  = 1'b1;
            mem_wadrs_d = pick_s ? req_wadrs[2*ADDR_W-1:ADDR_W] : req_wadrs[ADDR_W-1:0];
            mem_wdata_d = pick_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          end else begin
            mem_r_en_d  = 1'b1;
            mem_radrs_d = pick_s ? req_radrs[2*ADDR_W-1:ADDR_W] : req_radrs[ADDR_W-1:0];
          end
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion of the wrong type does not finish the transaction.
        if ((!op_wr_q && mem_r_valid) || (op_wr_q && mem_w_valid)) begin
          ack_d       = gnt_q ? 2'b10 : 2'b01;
          ack_rdata_d = op_wr_q ? '0 : mem_rdata;
          state_d     = S_RESP;
        end else if (timer_inc_s == TW'(TIMEOUT)) begin
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          ack_err_d = 1'b1;
          timer_d   = timer_inc_s;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      S_RESP: begin
        last_grant_d = gnt_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      op_wr_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      ack_q        <= 2'b00;
      ack_err_q    <= 1'b0;
      ack_rdata_q  <= '0;
      busy_q       <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_radrs_q  <= '0;
      mem_wadrs_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      op_wr_q      <= op_wr_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      ack_q        <= ack_d;
      ack_err_q    <= ack_err_d;
      ack_rdata_q  <= ack_rdata_d;
      busy_q       <= busy_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_radrs_q  <= mem_radrs_d;
      mem_wadrs_q  <= mem_wadrs_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign ack_err   = ack_err_q;
  assign ack_rdata = ack_rdata_q;
  assign busy      = busy_q;
  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign mem_radrs = mem_radrs_q;
  assign mem_wadrs = mem_wadrs_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic.
// A transaction-level request/grant model and a behavioural memory supply every expected value.
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_rd, req_wr;
  logic [2*AW-1:0] req_radrs, req_wadrs;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      ack;
  logic            ack_err, busy, mem_r_en, mem_w_en;
  logic [DW-1:0]   ack_rdata, mem_wdata;
  logic [AW-1:0]   mem_radrs, mem_wadrs;
  logic            mem_r_valid = 1'b0, mem_w_valid = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int wait_n;

  // Model of the pending requests as the requesters hold them.
  bit            p_rd [2];
  bit            p_wr [2];
  logic [AW-1:0] p_radr [2];
  logic [AW-1:0] p_wadr [2];
  logic [DW-1:0] p_wd [2];
  bit            last_g;
  bit [DW-1:0]   mem [0:2**AW-1];
  bit [DW-1:0]   ref_mem [0:2**AW-1];
  logic [AW-1:0] t3_adrs [4];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_radrs(req_radrs), .req_wadrs(req_wadrs), .req_wdata(req_wdata),
    .ack(ack), .ack_err(ack_err), .ack_rdata(ack_rdata), .busy(busy),
    .mem_r_en(mem_r_en), .mem_radrs(mem_radrs),
    .mem_w_en(mem_w_en), .mem_wadrs(mem_wadrs), .mem_wdata(mem_wdata),
    .mem_r_valid(mem_r_valid), .mem_w_valid(mem_w_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic drive();
    req_rd    = {p_rd[1], p_rd[0]};
    req_wr    = {p_wr[1], p_wr[0]};
    req_radrs = {p_radr[1], p_radr[0]};
    req_wadrs = {p_wadr[1], p_wadr[0]};
    req_wdata = {p_wd[1], p_wd[0]};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serve one transaction: predict the grant, answer as the memory after lat cycles, check the ack.
  task automatic serve(input int lat, input bit no_resp, input bit spur);
    bit [1:0]      cand;
    bit            pick, opw, found, early;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd, exp_rd;
    int            ack_k;
    cand  = {p_rd[1] | p_wr[1], p_rd[0] | p_wr[0]};
    pick  = (cand == 2'b11) ? !last_g : cand[1];
    opw   = p_wr[pick];
    adr   = opw ? p_wadr[pick] : p_radr[pick];
    wd    = p_wd[pick];
    found = 1'b0;
    wait_n = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      wait_n++;
      found = mem_r_en | mem_w_en;
    end
    chk("issue_seen", 64'(found), 64'(1));
    if (!found) return;
    chk("en_type", 64'({mem_w_en, mem_r_en}), opw ? 64'(2) : 64'(1));
    chk("issue_adrs", opw ? 64'(mem_wadrs) : 64'(mem_radrs), 64'(adr));
    if (opw) chk("issue_wdata", 64'(mem_wdata), 64'(wd));
    chk("busy", 64'(busy), 64'(1));
    ack_k = no_resp ? TO + 1 : lat + 1;
    early = 1'b0;
    for (int k = 1; k <= ack_k; k++) begin
      @(negedge clk);
      mem_r_valid = 1'b0;
      mem_w_valid = 1'b0;
      if (k < ack_k) begin
        if (ack !== 2'b00) early = 1'b1;
        if (!no_resp && k == lat) begin
          if (opw) begin
            mem_w_valid = 1'b1;
            mem[adr] = wd;
          end else begin
            mem_r_valid = 1'b1;
            mem_rdata = mem[adr];
          end
        end else if (spur && k == 1) begin
          if (opw) begin
            mem_r_valid = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
          end else begin
            mem_w_valid = 1'b1;
          end
        end
      end
    end
    chk("no_early_ack", 64'(early), 64'(0));
    exp_rd = (opw || no_resp) ? '0 : ref_mem[adr];
    chk("ack", 64'(ack), pick ? 64'(2) : 64'(1));
    chk("ack_err", 64'(ack_err), 64'(no_resp));
    chk("ack_rdata", 64'(ack_rdata), 64'(exp_rd));
    if (opw && !no_resp) ref_mem[adr] = wd;
    if (opw) p_wr[pick] = 1'b0;
    else     p_rd[pick] = 1'b0;
    last_g = pick;
    drive();
  endtask

  initial begin
    bit found;
    for (int c = 0; c < 2; c++) begin
      p_rd[c] = 1'b0; p_wr[c] = 1'b0; p_radr[c] = '0; p_wadr[c] = '0; p_wd[c] = '0;
    end
    last_g = 1'b1;
    drive();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset with no requests.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_ctl", 64'({ack, ack_err, busy, mem_r_en, mem_w_en, mem_radrs, mem_wadrs}), 64'(0));
      chk("reset_data", 64'({ack_rdata, mem_wdata}), 64'(0));
    end

    // Both cores write continuously: grants alternate starting at core0.
    t3_adrs[0] = 11'h100; t3_adrs[1] = 11'h200; t3_adrs[2] = 11'h100; t3_adrs[3] = 11'h200;
    p_wadr[0] = 11'h100; p_wd[0] = 32'h11;
    p_wadr[1] = 11'h200; p_wd[1] = 32'h22;
    for (int i = 0; i < 4; i++) begin
      p_wr[0] = 1'b1; p_wr[1] = 1'b1;
      drive();
      serve(1, 1'b0, 1'b0);
      chk("t3_wadrs", 64'(mem_wadrs), 64'(t3_adrs[i]));
      if (i > 0) chk("t3_b2b", 64'(wait_n), 64'(2));
    end
    p_wr[0] = 1'b0; p_wr[1] = 1'b0;
    drive();

    // Core0 read with one-cycle memory latency.
    @(negedge clk);
    mem[11'h012] = 32'hDEAD_BEEF;
    ref_mem[11'h012] = 32'hDEAD_BEEF;
    p_rd[0] = 1'b1; p_radr[0] = 11'h012;
    drive();
    serve(1, 1'b0, 1'b0);
    chk("t2_issue_lat", 64'(wait_n), 64'(1));
    chk("t2_rdata", 64'(ack_rdata), 64'(32'hDEAD_BEEF));

    // Core1 read+write together while core0 also writes.
    p_rd[1] = 1'b1; p_wr[1] = 1'b1; p_radr[1] = 11'h200; p_wadr[1] = 11'h200; p_wd[1] = 32'h5A5A_0001;
    p_wr[0] = 1'b1; p_wadr[0] = 11'h300; p_wd[0] = 32'h0000_0303;
    drive();
    for (int i = 0; i < 3; i++) serve(2, 1'b0, 1'b0);
    chk("t4_read_last", 64'({ack, ack_rdata}), 64'({2'b10, 32'h5A5A_0001}));

    // Memory never answers: abort with error, then a normal transaction.
    p_rd[0] = 1'b1; p_radr[0] = 11'h012;
    drive();
    serve(1, 1'b1, 1'b0);
    p_wr[1] = 1'b1; p_wadr[1] = 11'h044; p_wd[1] = 32'h4444_4444;
    drive();
    serve(3, 1'b0, 1'b0);

    // Reset while waiting on the memory.
    @(negedge clk);
    p_rd[0] = 1'b1; p_radr[0] = 11'h055;
    drive();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      found = mem_r_en;
    end
    chk("t6_issue_seen", 64'(found), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_async_clear", 64'({ack, ack_err, busy, mem_r_en, mem_w_en, mem_radrs}), 64'(0));
    repeat (2) @(negedge clk);
    chk("t6_no_ack", 64'(ack), 64'(0));
    rst = 1'b0;
    last_g = 1'b1;
    p_rd[1] = 1'b1; p_radr[1] = 11'h066;
    drive();
    serve(1, 1'b0, 1'b0);
    chk("t6_core0_first", 64'(ack), 64'(1));
    serve(1, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < 2; c++) begin
        if (!p_rd[c] && !p_wr[c] && $urandom_range(0, 2) != 0) begin
          int kind;
          kind = int'($urandom_range(1, 3));
          p_wr[c]   = kind[0];
          p_rd[c]   = kind[1];
          p_radr[c] = AW'($urandom_range(0, 15));
          p_wadr[c] = AW'($urandom_range(0, 15));
          p_wd[c]   = DW'($urandom);
        end
      end
      drive();
      if (p_rd[0] || p_wr[0] || p_rd[1] || p_wr[1])
        serve(int'($urandom_range(1, 4)), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      else
        @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
